// File: rtl/store_buffer.sv
// Store buffer: FIFO of committed stores drained to dmem_ultra in program order,
// with exact-match word forwarding and partial-overlap stall detection for loads.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    input  logic [1:0]        st_size,
    output logic              st_ready,
    input  logic              mem_busy,
    output logic              write_enable_dmem,
    output logic [ADDR_W-1:0] mem_WA,
    output logic [31:0]       mem_WD,
    output logic [1:0]        store,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              fwd_hit,
    output logic [31:0]       fwd_data,
    output logic              ld_stall,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [1:0] SIZE_SW = 2'b00;

    logic [ADDR_W-1:0] addr_q  [DEPTH];
    logic [31:0]       data_q  [DEPTH];
    logic [1:0]        size_q  [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count;

    logic push, pop;

    assign empty             = (count == '0);
    assign st_ready          = (count != FULL_CNT);
    assign push              = st_valid && st_ready;
    assign write_enable_dmem = !empty && !mem_busy;
    assign pop               = write_enable_dmem;

    assign mem_WA = empty ? '0 : addr_q[head];
    assign mem_WD = empty ? '0 : data_q[head];
    assign store  = empty ? '0 : size_q[head];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            valid_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                size_q[i] <= '0;
            end
        end else begin
            if (push) begin
                addr_q[tail]  <= st_addr;
                data_q[tail]  <= st_data;
                size_q[tail]  <= st_size;
                valid_q[tail] <= 1'b1;
                tail          <= tail + 1'b1;
            end
            if (pop) begin
                valid_q[head] <= 1'b0;
                head          <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Walk oldest to youngest from head so the last match wins (youngest store).
    logic             any_match;
    logic [PTR_W-1:0] sel;
    logic [PTR_W-1:0] idx;

    always_comb begin
        any_match = 1'b0;
        sel       = '0;
        idx       = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (valid_q[idx] && (addr_q[idx][ADDR_W-1:2] == ld_addr[ADDR_W-1:2])) begin
                any_match = 1'b1;
                sel       = idx;
            end
        end
    end

    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        ld_stall = 1'b0;
        if (ld_valid && any_match) begin
            if (size_q[sel] == SIZE_SW && addr_q[sel] == ld_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[sel];
            end else begin
                ld_stall = 1'b1;
            end
        end
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- FIFO write buffer between the MEM-stage store path and dmem_ultra.
- Accepts committed stores at one per cycle and drains them to data memory in program order, one per cycle, whenever memory is not busy.
- Lets pipeline loads forward exact-match word data from pending stores.
- Stalls loads that partially overlap a pending store.

Parameters:
- DEPTH, 4, number of buffered stores; must be a power of 2, minimum 2.
- ADDR_W, 32, address width in bits.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- st_valid  input  1  store request from MEM stage.
- st_addr  input  ADDR_W  store byte address.
- st_data  input  32  store data.
- st_size  input  2  00 SW, 01 SH, 10 SB; same encoding as dmem_ultra store.
- st_ready  output  1  buffer can accept a store this cycle.
- mem_busy  input  1  dmem port is taken this cycle; suppresses drain.
- write_enable_dmem  output  1  drain write strobe to dmem_ultra.
- mem_WA  output  ADDR_W  drain address.
- mem_WD  output  32  drain data.
- store  output  2  drain size, passed unchanged.
- ld_valid  input  1  load present in MEM stage.
- ld_addr  input  ADDR_W  load byte address.
- fwd_hit  output  1  forward fwd_data instead of memory data.
- fwd_data  output  32  forwarded word.
- ld_stall  output  1  load must wait for the buffer to drain the conflicting entry.
- empty  output  1  no valid entries.

Behaviour:
- Storage and pointers:
  - Circular array of DEPTH entries {addr, data, size}.
  - Head pointer, tail pointer and count (log2(DEPTH)+1 bits) are registered.
  - Pointers wrap modulo DEPTH.
- Reset (asynchronous):
  - count, head and tail go to 0; all entries are invalid and their fields 0.
  - Outputs after reset: empty=1, st_ready=1, write_enable_dmem=0, mem_WA=0, mem_WD=0, store=0, fwd_hit=0, fwd_data=0, ld_stall=0.
  - Reset mid-drain discards all entries; no further write is issued.
- st_ready:
  - st_ready = (count != DEPTH), computed from registered count only.
  - When full, st_ready=0 even if a pop occurs the same cycle; there is no full-bypass.
- Push:
  - Occurs when st_valid && st_ready. The entry is written at the tail and the tail advances.
  - st_valid while st_ready=0 is ignored; the upstream stage must hold the request.
- Drain:
  - write_enable_dmem = !empty && !mem_busy.
  - mem_WA, mem_WD and store always reflect the head entry combinationally; they are 0 when empty.
  - Pop occurs on the clock edge where write_enable_dmem=1; the head advances.
- Latency: a store pushed in cycle n is first presented with write_enable_dmem=1 in cycle n+1 if the buffer was empty and mem_busy=0. There is no same-cycle pass-through.
- Simultaneous push and pop: count is unchanged and both pointers advance; legal whenever not full.
- Forwarding (combinational, evaluated only when ld_valid=1; otherwise fwd_hit=0 and ld_stall=0):
  - match_i = entry i valid && entry.addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2].
  - Select the youngest matching entry, i.e. the one closest to the tail.
  - fwd_hit = 1 iff that entry has size SW and entry.addr == ld_addr exactly. fwd_data = its data; otherwise fwd_data = 0.
  - ld_stall = any match && !fwd_hit.
  - The entry being drained this cycle is still considered.
  - A store pushed in the same cycle is not considered; it is older in program order only through the pipeline, so the hazard cannot occur.
- ld_stall clears combinationally once the conflicting entries have popped.
- empty = (count == 0).

Test Plan:
- Reset then single SW addr=0x100 data=0xDEADBEEF with mem_busy=0 -> next cycle write_enable_dmem=1, mem_WA=0x100, mem_WD=0xDEADBEEF, store=00; following cycle empty=1.
- mem_busy=1, push 4 stores (0x10, 0x14, 0x18, 0x1C) -> st_ready=0 after 4th; 5th st_valid ignored. Release mem_busy -> 4 consecutive writes in address order, then empty=1 and st_ready=1.
- mem_busy=1, SW 0x100=0x11111111 then SW 0x100=0x22222222; load 0x100 -> fwd_hit=1, fwd_data=0x22222222, ld_stall=0.
- mem_busy=1, SB 0x104 data=0xAB; load 0x104 -> ld_stall=1, fwd_hit=0. Deassert mem_busy -> ld_stall drops the cycle after the drain write. Load 0x108 -> no stall.
- Buffer full; assert st_valid and pop in the same cycle -> push rejected and count becomes 3. Next cycle push accepted and count returns to 4.
- 2 entries pending, assert rst mid-drain -> write_enable_dmem=0 and empty=1 immediately. After release, no stale write appears.
